// File: rtl/ed25519_out_serializer_if.sv
// Handshake bundle between the point-multiplication core, the output
// serializer and the top-level output pins.
interface ed25519_out_serializer_if #(
   parameter int DATA_W = 64,
   parameter int PATN_W = 256
);
   logic              i_res_valid;
   logic              o_res_ready;
   logic [PATN_W-1:0] i_res_x;
   logic [PATN_W-1:0] i_res_y;
   logic              o_out_valid;
   logic              i_out_ready;
   logic [DATA_W-1:0] o_out_data;

   modport slave (
      input  i_res_valid, i_res_x, i_res_y, i_out_ready,
      output o_res_ready, o_out_valid, o_out_data
   );

   modport master (
      output i_res_valid, i_res_x, i_res_y, i_out_ready,
      input  o_res_ready, o_out_valid, o_out_data
   );
endinterface

// File: rtl/ed25519_out_serializer.sv
// Reduces an affine (x, y) result modulo 2^255-19 and streams it as
// 64-bit beats, x most-significant beat first, y least-significant last.
module ed25519_out_serializer #(
   parameter  int DATA_W = 64,
   parameter  int PATN_W = 256,
   localparam int BEATS  = 2 * PATN_W / DATA_W
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   ed25519_out_serializer_if.slave bus,
   output logic                    o_busy
);
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0]  LAST = CNT_W'(BEATS - 1);
   // p = 2^255 - 19
   localparam logic [PATN_W-1:0] P = {1'b0, {(PATN_W-6){1'b1}}, 5'b01101};

   typedef enum logic [1:0] {IDLE, REDUCE, SEND} state_t;

   state_t            state_q, state_d;
   logic              res_ready_q, res_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PATN_W-1:0] x_q, x_d, y_q, y_d;

   logic [PATN_W-1:0] x_red, y_red;
   logic              accept, xfer;

   assign x_red  = (x_q >= P) ? (x_q - P) : x_q;
   assign y_red  = (y_q >= P) ? (y_q - P) : y_q;
   assign accept = bus.i_res_valid && res_ready_q;
   assign xfer   = out_valid_q && bus.i_out_ready;

   function automatic logic [DATA_W-1:0] beat_sel(input logic [PATN_W-1:0] x,
                                                  input logic [PATN_W-1:0] y,
                                                  input logic [CNT_W-1:0]  k);
      logic [2*PATN_W-1:0] sh;
      sh = {x, y} << (k * DATA_W);
      return sh[2*PATN_W-1 -: DATA_W];
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         res_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
      end else begin
         state_q     <= state_d;
         res_ready_q <= res_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = REDUCE;
         REDUCE:  state_d = SEND;
         SEND:    if (xfer && cnt_q == LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      res_ready_d = res_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      case (state_q)
         IDLE: begin
            res_ready_d = 1'b1;
            if (accept) begin
               res_ready_d = 1'b0;
               x_d         = bus.i_res_x;
               y_d         = bus.i_res_y;
            end
         end
         REDUCE: begin
            // Buffers keep the canonical values so later beats slice them directly.
            x_d         = x_red;
            y_d         = y_red;
            out_data_d  = x_red[PATN_W-1 -: DATA_W];
            out_valid_d = 1'b1;
            cnt_d       = '0;
         end
         SEND: begin
            if (xfer) begin
               if (cnt_q == LAST) begin
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  res_ready_d = 1'b1;
               end else begin
                  cnt_d      = cnt_q + 1'b1;
                  out_data_d = beat_sel(x_q, y_q, cnt_q + 1'b1);
               end
            end
         end
         default: begin
            res_ready_d = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.o_res_ready = res_ready_q;
   assign bus.o_out_valid = out_valid_q;
   assign bus.o_out_data  = out_data_q;
   assign o_busy          = busy_q;
endmodule

// File: tb/tb_ed25519_out_serializer.sv
// Randomized bench for the ed25519 output serializer against a plain
// arithmetic model of reduction and beat ordering.
module tb_ed25519_out_serializer;
   localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   ed25519_out_serializer_if bif ();

   ed25519_out_serializer dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .bus    (bif),
      .o_busy (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [255:0] in_x[$];
   logic [255:0] in_y[$];
   logic [63:0]  got[$];
   int           acc_cyc[$];
   int           xfer_cyc[$];
   int           vld_first;
   int           stall_bad;

   function automatic logic [63:0] ref_beat(input logic [255:0] x, input logic [255:0] y,
                                            input int k);
      logic [255:0] rx, ry;
      logic [511:0] c;
      rx = (x >= P) ? x - P : x;
      ry = (y >= P) ? y - P : y;
      c  = {rx, ry} >> (64 * (7 - k));
      return c[63:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v = {v[223:0], $urandom()};
      return v;
   endfunction

   // Upstream holds each queued result until accepted; downstream ready is
   // always 1 (mode 0) or random (mode 1). Collects transferred beats.
   task automatic run_stream(input int mode, input int n_beats, input int budget);
      int          cyc = 0;
      int          idx = 0;
      logic        stalled = 1'b0;
      logic        acc_pending = 1'b0;
      logic        rdy;
      logic [63:0] held = '0;
      got.delete(); acc_cyc.delete(); xfer_cyc.delete();
      vld_first = -1;
      stall_bad = 0;
      while (got.size() < n_beats && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (acc_pending) idx++;
         if (stalled && (bif.o_out_valid !== 1'b1 || bif.o_out_data !== held)) stall_bad++;
         if (bif.o_out_valid === 1'b1 && vld_first < 0) vld_first = cyc;
         bif.i_res_valid = (idx < in_x.size());
         if (idx < in_x.size()) begin
            bif.i_res_x = in_x[idx];
            bif.i_res_y = in_y[idx];
         end
         acc_pending = bif.i_res_valid && (bif.o_res_ready === 1'b1);
         if (acc_pending) acc_cyc.push_back(cyc);
         rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         bif.i_out_ready = rdy;
         if (bif.o_out_valid === 1'b1 && rdy) begin
            got.push_back(bif.o_out_data);
            xfer_cyc.push_back(cyc);
            stalled = 1'b0;
         end else begin
            stalled = (bif.o_out_valid === 1'b1);
            held    = bif.o_out_data;
         end
      end
      @(negedge clk);
      bif.i_out_ready = 1'b0;
      bif.i_res_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bif.i_res_valid = 1'b0;
      bif.i_res_x = '0;
      bif.i_res_y = '0;
      bif.i_out_ready = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (bif.o_res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready got %b exp 1", bif.o_res_ready); end
      checks++; if (bif.o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bif.o_out_valid); end
      checks++; if (bif.o_out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", bif.o_out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [255:0] x = '0, y = '0;
      for (int i = 1; i <= 32; i++) begin
         x = {x[247:0], 8'(i)};
         y = {y[247:0], 8'(i + 32)};
      end
      in_x = '{x}; in_y = '{y};
      run_stream(0, 8, 40);
      checks++; if (got.size() != 8) begin errors++; $display("FAIL basic_count got %0d exp 8", got.size()); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] !== ref_beat(x, y, k)) begin errors++; $display("FAIL basic_beat%0d got %h exp %h", k, got[k], ref_beat(x, y, k)); end
      end
      checks++; if (got[0] !== 64'h0102030405060708) begin errors++; $display("FAIL basic_first got %h exp 0102030405060708", got[0]); end
      checks++; if (got[7] !== 64'h393A3B3C3D3E3F40) begin errors++; $display("FAIL basic_last got %h exp 393a3b3c3d3e3f40", got[7]); end
      checks++; if (vld_first - acc_cyc[0] != 2) begin errors++; $display("FAIL basic_latency got %0d exp 2", vld_first - acc_cyc[0]); end
      checks++; if (xfer_cyc[7] - xfer_cyc[0] != 7) begin errors++; $display("FAIL basic_no_bubble got %0d exp 7", xfer_cyc[7] - xfer_cyc[0]); end
      checks++; if (bif.o_res_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b exp 1", bif.o_res_ready); end
      checks++; if (bif.o_out_valid !== 1'b0 || bif.o_out_data !== 64'd0) begin errors++; $display("FAIL basic_idle_after got %b/%h exp 0/0", bif.o_out_valid, bif.o_out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
   endtask

   task automatic test_reduction();
      logic [63:0] exp;
      in_x = '{P}; in_y = '{P + 256'd5};
      run_stream(0, 8, 40);
      checks++; if (got.size() != 8) begin errors++; $display("FAIL red_count got %0d exp 8", got.size()); end
      for (int k = 0; k < got.size(); k++) begin
         exp = (k == 7) ? 64'd5 : 64'd0;
         checks++; if (got[k] !== exp) begin errors++; $display("FAIL red_p_beat%0d got %h exp %h", k, got[k], exp); end
      end
      in_x = '{P - 256'd1, (P << 1) - 256'd1}; in_y = '{256'd0, 256'd1};
      run_stream(0, 16, 60);
      checks++; if (got.size() != 16) begin errors++; $display("FAIL red2_count got %0d exp 16", got.size()); end
      checks++; if (got[0] !== 64'h7FFFFFFFFFFFFFFF) begin errors++; $display("FAIL red_pm1_first got %h exp 7fffffffffffffff", got[0]); end
      checks++; if (got[3] !== 64'hFFFFFFFFFFFFFFEC) begin errors++; $display("FAIL red_pm1_b3 got %h exp ffffffffffffffec", got[3]); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] !== ref_beat(in_x[k/8], in_y[k/8], k % 8)) begin errors++; $display("FAIL red2_beat%0d got %h exp %h", k, got[k], ref_beat(in_x[k/8], in_y[k/8], k % 8)); end
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] x, y;
      void'($urandom(1));
      x = rand256() & ~(256'd1 << 255);
      y = P + 256'($urandom_range(0, 100));
      in_x = '{x}; in_y = '{y};
      run_stream(1, 8, 200);
      checks++; if (got.size() != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", got.size()); end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stall_bad); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] !== ref_beat(x, y, k)) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", k, got[k], ref_beat(x, y, k)); end
      end
   endtask

   task automatic test_reset_midstream();
      logic [255:0] x, y;
      in_x = '{rand256()}; in_y = '{rand256() >> 1};
      run_stream(0, 3, 40);
      // beat 3 is taken at this negedge; reset is applied right after it transfers
      bif.i_out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      bif.i_out_ready = 1'b0;
      @(negedge clk);
      checks++; if (bif.o_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bif.o_out_valid); end
      checks++; if (busy !== 1'b0 || bif.o_res_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state got busy=%b rdy=%b exp 0/1", busy, bif.o_res_ready); end
      rst = 1'b0;
      x = rand256() >> 1;
      y = P + 256'd77;
      in_x = '{x}; in_y = '{y};
      run_stream(0, 8, 40);
      checks++; if (got.size() != 8) begin errors++; $display("FAIL rstmid_count got %0d exp 8", got.size()); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] !== ref_beat(x, y, k)) begin errors++; $display("FAIL rstmid_beat%0d got %h exp %h", k, got[k], ref_beat(x, y, k)); end
      end
   endtask

   task automatic test_back_to_back();
      in_x = '{rand256() >> 1, P + 256'd3};
      in_y = '{P + 256'd9, rand256() >> 1};
      run_stream(0, 16, 60);
      checks++; if (got.size() != 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", got.size()); end
      checks++; if (acc_cyc.size() != 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", acc_cyc.size()); end
      checks++; if (acc_cyc[1] != xfer_cyc[7] + 1) begin errors++; $display("FAIL b2b_second_accept got %0d exp %0d", acc_cyc[1], xfer_cyc[7] + 1); end
      checks++; if (acc_cyc[1] - acc_cyc[0] != 10) begin errors++; $display("FAIL b2b_period got %0d exp 10", acc_cyc[1] - acc_cyc[0]); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] !== ref_beat(in_x[k/8], in_y[k/8], k % 8)) begin errors++; $display("FAIL b2b_beat%0d got %h exp %h", k, got[k], ref_beat(in_x[k/8], in_y[k/8], k % 8)); end
      end
   endtask

   task automatic test_random();
      in_x.delete(); in_y.delete();
      for (int r = 0; r < 6; r++) begin
         in_x.push_back(($urandom_range(0, 1) != 0) ? (rand256() >> 1) : P + 256'($urandom_range(0, 1000)));
         in_y.push_back(($urandom_range(0, 1) != 0) ? (rand256() >> 1) : P + 256'($urandom_range(0, 1000)));
      end
      run_stream(1, 48, 1000);
      checks++; if (got.size() != 48) begin errors++; $display("FAIL rnd_count got %0d exp 48", got.size()); end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL rnd_stable got %0d changes exp 0", stall_bad); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] !== ref_beat(in_x[k/8], in_y[k/8], k % 8)) begin errors++; $display("FAIL rnd_beat%0d got %h exp %h", k, got[k], ref_beat(in_x[k/8], in_y[k/8], k % 8)); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reduction();
      test_backpressure();
      test_reset_midstream();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
